// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared width codes, FSM state type and byte-lane helpers for the data-memory LSU
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // Byte-write enables for a store of the given width at the given byte offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the LSB-justified store data so every enabled lane sees its byte.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Pick the addressed byte/halfword out of a memory word and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_W:    return w;
            F3_BU:   return {24'h0, b};
            F3_HU:   return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - word-organised storage with byte-write enables, synchronous write and read
module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Per-lane write; lanes without an enable keep their previous byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    // Registered read; holds the last word when no load is issued.
    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I load/store unit over a byte-enabled data RAM with power-up clear
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LAT      = 1,
    parameter int INIT_CLEAR  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        r_state;
    logic          r_ready;
    logic [AW-1:0] r_init_cnt;

    logic          r_s1_valid;
    logic          r_s1_err;
    logic          r_s1_we;
    logic [2:0]    r_s1_funct3;
    logic [1:0]    r_s1_lane;

    logic          w_accept;
    logic          w_illegal;
    logic          w_misalign;
    logic          w_oor;
    logic          w_err;
    logic [AW-1:0] w_word;
    logic [3:0]    w_ram_we;
    logic [AW-1:0] w_ram_waddr;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_ram_rdata;
    logic [31:0]   w_s1_rdata;

    assign req_ready  = r_ready;
    assign w_accept   = req_valid & r_ready;
    assign w_word     = req_addr[AW+1:2];
    // Codes x11 never exist; 110/111 are not loads, and no 1xx code is a store.
    assign w_illegal  = (req_funct3[1:0] == 2'b11) | (req_funct3[2] & (req_we | req_funct3[1]));
    assign w_misalign = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                        ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    assign w_oor      = |req_addr[31:AW+2];
    assign w_err      = w_illegal | w_misalign | w_oor;

    // Clear-after-reset sequencer: one word per cycle, then accept requests forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            r_ready    <= 1'b0;
            r_init_cnt <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == AW'(DEPTH_WORDS - 1)) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Write port owner: the clear counter during INIT, otherwise error-free stores.
    always_comb begin
        w_ram_we    = 4'b0000;
        w_ram_waddr = w_word;
        w_ram_wdata = store_data(req_funct3, req_wdata);
        if (r_state == ST_INIT) begin
            w_ram_we    = 4'b1111;
            w_ram_waddr = r_init_cnt;
            w_ram_wdata = 32'h0;
        end else if (w_accept && req_we && !w_err) begin
            w_ram_we    = lane_mask(req_funct3, req_addr[1:0]);
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_accept & ~req_we & ~w_err),
        .i_raddr (w_word),
        .o_rdata (w_ram_rdata)
    );

    // Request attributes travel alongside the RAM read to shape the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_err    <= 1'b0;
            r_s1_we     <= 1'b0;
            r_s1_funct3 <= 3'b000;
            r_s1_lane   <= 2'b00;
        end else begin
            r_s1_valid  <= w_accept;
            r_s1_err    <= w_err;
            r_s1_we     <= req_we;
            r_s1_funct3 <= req_funct3;
            r_s1_lane   <= req_addr[1:0];
        end
    end

    assign w_s1_rdata = (r_s1_valid && !r_s1_err && !r_s1_we) ?
                        load_extend(r_s1_funct3, r_s1_lane, w_ram_rdata) : 32'h0;

    if (RD_LAT == 2) begin : g_lat2
        logic        r_s2_valid;
        logic        r_s2_err;
        logic [31:0] r_s2_rdata;

        // Extra output register; memory timing is the same as the single-cycle case.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_valid <= 1'b0;
                r_s2_err   <= 1'b0;
                r_s2_rdata <= 32'h0;
            end else begin
                r_s2_valid <= r_s1_valid;
                r_s2_err   <= r_s1_valid & r_s1_err;
                r_s2_rdata <= w_s1_rdata;
            end
        end

        assign rsp_valid = r_s2_valid;
        assign rsp_err   = r_s2_err;
        assign rsp_rdata = r_s2_rdata;
    end else begin : g_lat1
        assign rsp_valid = r_s1_valid;
        assign rsp_err   = r_s1_valid & r_s1_err;
        assign rsp_rdata = w_s1_rdata;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu with RD_LAT=1 and RD_LAT=2 instances
module tb_dmem_lsu;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rsp_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic        a_rst_n, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_err;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_wdata, a_rdata;

    logic        b_rst_n, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err;
    logic [2:0]  b_f3;
    logic [31:0] b_addr, b_wdata, b_rdata;

    dmem_lsu #(.DEPTH_WORDS(1024), .RD_LAT(1), .INIT_CLEAR(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_funct3(a_f3), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_rsp_err)
    );

    dmem_lsu #(.DEPTH_WORDS(1024), .RD_LAT(2), .INIT_CLEAR(1)) u_b (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_funct3(b_f3), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_rsp_err)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    vec_t vq[$];
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every response must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        if (a_rsp_valid === 1'b1) begin
            rsp_count++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=valid required=none");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("rsp%0d_err", e.id), 32'(a_rsp_err), 32'(e.err));
                check($sformatf("rsp%0d_rdata", e.id), a_rdata, e.rdata);
                check($sformatf("rsp%0d_latency", e.id), cyc, e.cyc);
            end
        end
    end

    initial begin
        int n;
        int t0;
        bit saw_rsp;

        a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_f3 = 3'b0; a_addr = 32'h0; a_wdata = 32'h0;
        b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_f3 = 3'b0; b_addr = 32'h0; b_wdata = 32'h0;

        // we, f3, addr, wdata, exp_err, exp_rdata
        vq.push_back('{1'b0, F3_W,   32'h3FC,  32'h0,        1'b0, 32'h00000000});
        vq.push_back('{1'b1, F3_W,   32'h10,   32'h80F07F01, 1'b0, 32'h00000000});
        vq.push_back('{1'b0, F3_B,   32'h10,   32'h0,        1'b0, 32'h00000001});
        vq.push_back('{1'b0, F3_B,   32'h11,   32'h0,        1'b0, 32'h0000007F});
        vq.push_back('{1'b0, F3_B,   32'h12,   32'h0,        1'b0, 32'hFFFFFFF0});
        vq.push_back('{1'b0, F3_B,   32'h13,   32'h0,        1'b0, 32'hFFFFFF80});
        vq.push_back('{1'b0, F3_BU,  32'h13,   32'h0,        1'b0, 32'h00000080});
        vq.push_back('{1'b1, F3_W,   32'h20,   32'h11223344, 1'b0, 32'h00000000});
        vq.push_back('{1'b1, F3_H,   32'h22,   32'h5A5ABEEF, 1'b0, 32'h00000000});
        vq.push_back('{1'b0, F3_W,   32'h20,   32'h0,        1'b0, 32'hBEEF3344});
        vq.push_back('{1'b0, F3_H,   32'h22,   32'h0,        1'b0, 32'hFFFFBEEF});
        vq.push_back('{1'b0, F3_HU,  32'h22,   32'h0,        1'b0, 32'h0000BEEF});
        vq.push_back('{1'b1, F3_W,   32'h40,   32'hA5A5A5A5, 1'b0, 32'h00000000});
        vq.push_back('{1'b0, F3_W,   32'h40,   32'h0,        1'b0, 32'hA5A5A5A5});
        vq.push_back('{1'b0, F3_W,   32'h41,   32'h0,        1'b1, 32'h00000000});
        vq.push_back('{1'b1, F3_H,   32'h23,   32'h0000FFFF, 1'b1, 32'h00000000});
        vq.push_back('{1'b0, F3_W,   32'h1000, 32'h0,        1'b1, 32'h00000000});
        vq.push_back('{1'b0, 3'b011, 32'h30,   32'h0,        1'b1, 32'h00000000});
        vq.push_back('{1'b1, F3_BU,  32'h20,   32'hFFFFFFFF, 1'b1, 32'h00000000});
        vq.push_back('{1'b0, 3'b110, 32'h20,   32'h0,        1'b1, 32'h00000000});
        vq.push_back('{1'b0, F3_W,   32'h20,   32'h0,        1'b0, 32'hBEEF3344});
        vq.push_back('{1'b1, F3_B,   32'h21,   32'h777777AA, 1'b0, 32'h00000000});
        vq.push_back('{1'b0, F3_W,   32'h20,   32'h0,        1'b0, 32'hBEEFAA44});
        vq.push_back('{1'b0, F3_W,   32'hFFC,  32'h0,        1'b0, 32'h00000000});
        vq.push_back('{1'b0, F3_H,   32'h13,   32'h0,        1'b1, 32'h00000000});

        // Reset values of the RD_LAT=1 instance
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(a_req_ready), 32'h0);
        check("rst_rsp_valid", 32'(a_rsp_valid), 32'h0);
        check("rst_rsp_rdata", a_rdata, 32'h0);
        check("rst_rsp_err",   32'(a_rsp_err), 32'h0);

        // INIT duration
        a_rst_n = 1'b1;
        n = 0;
        while (a_req_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_init_cycles", n, 1024);

        // Back-to-back vector stream, one request per cycle
        foreach (vq[i]) begin
            check($sformatf("ready_vec%0d", i), 32'(a_req_ready), 32'h1);
            a_req_valid = 1'b1;
            a_req_we    = vq[i].we;
            a_f3        = vq[i].f3;
            a_addr      = vq[i].addr;
            a_wdata     = vq[i].wdata;
            sb_q.push_back('{i, vq[i].err, vq[i].rdata, cyc + 1});
            @(posedge clk); #1;
        end
        a_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        check("rsp_count", rsp_count, vq.size());

        // RD_LAT=2 instance: INIT, then a single load with two-cycle latency
        @(negedge clk);
        b_rst_n = 1'b1;
        n = 0;
        while (b_req_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_init_cycles", n, 1024);

        b_req_valid = 1'b1; b_req_we = 1'b0; b_f3 = F3_W; b_addr = 32'h0;
        t0 = cyc;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        n = 0;
        while (b_rsp_valid !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_latency", cyc - t0, 2);
        check("b_rdata", b_rdata, 32'h0);
        check("b_err", 32'(b_rsp_err), 32'h0);
        @(posedge clk); #1;
        check("b_pulse", 32'(b_rsp_valid), 32'h0);

        // Two loads in flight, then asynchronous reset
        b_req_valid = 1'b1; b_addr = 32'h0;
        @(posedge clk); #1;
        b_addr = 32'h4;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        b_rst_n = 1'b0;
        #1;
        check("b_rst_rsp_valid", 32'(b_rsp_valid), 32'h0);
        check("b_rst_req_ready", 32'(b_req_ready), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        b_rst_n = 1'b1;
        n = 0;
        saw_rsp = 1'b0;
        while (b_req_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (b_rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        repeat (4) begin
            @(posedge clk); #1;
            if (b_rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        check("b_reinit_cycles", n, 1024);
        check("b_no_stale_rsp", 32'(saw_rsp), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
